// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - compare codes and FSM state encoding for the bit-serial magnitude comparator
package mag_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mag_serial_cmp.sv
// rtl/mag_serial_cmp.sv - bit-serial unsigned magnitude comparator, MSB first, valid/ready in and out
module mag_serial_cmp
  import mag_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       decided,
  output logic [1:0] o,
  output logic       o_valid,
  input  logic       o_ready
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             gt;
  logic             lt;
  logic             gt_next;
  logic             lt_next;

  // The first differing bit (MSB first) decides; later bits only keep word alignment.
  always_comb begin
    gt_next = gt;
    lt_next = lt;
    if (!gt && !lt) begin
      gt_next = a_bit & ~b_bit;
      lt_next = ~a_bit & b_bit;
    end
  end

  assign in_ready = (state == ST_SHIFT);
  assign decided  = (gt | lt) && (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_SHIFT;
      cnt     <= '0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      o       <= CMP_EQ;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (in_valid) begin
            gt <= gt_next;
            lt <= lt_next;
            if (cnt == LAST) begin
              o       <= {gt_next, lt_next};
              o_valid <= 1'b1;
              cnt     <= '0;
              state   <= ST_HOLD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // o keeps its last value after the handshake; o_valid marks it stale.
          if (o_ready) begin
            o_valid <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        default: begin
          state <= ST_SHIFT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_serial_cmp.sv
// tb/tb_mag_serial_cmp.sv - scoreboard bench for mag_serial_cmp with directed word sequences
module tb_mag_serial_cmp;
  import mag_pkg::*;

  localparam int WIDTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       a_bit;
  logic       b_bit;
  logic       decided;
  logic [1:0] o;
  logic       o_valid;
  logic       o_ready;

  int n_checks;
  int n_fail;
  logic [1:0] exp_q[$];

  mag_serial_cmp #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .decided  (decided),
    .o        (o),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives nbeats beats of a/b MSB first; pushes the expected code only for full words.
  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int nbeats, input int max_gap);
    logic mg, ml;
    logic [1:0] exp_o;
    int gap, t;
    mg = 1'b0;
    ml = 1'b0;
    if (nbeats == WIDTH)
      exp_q.push_back((a > b) ? CMP_GT : ((a < b) ? CMP_LT : CMP_EQ));
    for (int i = 0; i < nbeats; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
        check("idle_no_result", o_valid, 1'b0);
      end
      in_valid = 1'b1;
      a_bit    = a[WIDTH-1-i];
      b_bit    = b[WIDTH-1-i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      n_checks++;
      assert (in_ready === 1'b1) else begin
        n_fail++;
        $error("FAIL in_ready_timeout: observed %b expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!mg && !ml) begin
        mg = a_bit & ~b_bit;
        ml = ~a_bit & b_bit;
      end
      if (i < WIDTH - 1) begin
        check("decided", decided, mg | ml);
        check("no_early_result", o_valid, 1'b0);
      end else begin
        check("o_valid_latency", o_valid, 1'b1);
        check("decided_in_hold", decided, 1'b0);
        check("in_ready_in_hold", in_ready, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL scoreboard_empty: observed result %b with nothing expected", o);
        end else begin
          exp_o = exp_q.pop_front();
          check("result", o, exp_o);
        end
      end
    end
  endtask

  // Consumer takes the result (o_ready already 1); o_valid must drop, o must stay.
  task automatic take_result;
    logic [1:0] last_o;
    last_o = o;
    @(posedge clk); #1;
    check("o_valid_after_take", o_valid, 1'b0);
    check("o_retained", o, last_o);
    check("in_ready_after_take", in_ready, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    o_ready  = 1'b1;

    #12;
    check("rst_o", o, CMP_EQ);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_decided", decided, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Equal operands: decided never rises.
    send_word(4'b1011, 4'b1011, WIDTH, 0);
    take_result();

    // Differ at beat 2, A larger.
    send_word(4'b1100, 4'b1011, WIDTH, 0);
    take_result();

    // Differ at beat 1, A smaller; remaining bits favour A but must not matter.
    send_word(4'b0111, 4'b1000, WIDTH, 0);
    take_result();

    // Idle gaps between beats.
    send_word(4'b0001, 4'b0000, WIDTH, 3);
    take_result();
    send_word(4'b0110, 4'b0110, WIDTH, 3);
    take_result();

    // Backpressure with junk beats offered during HOLD.
    o_ready = 1'b0;
    send_word(4'b1001, 4'b1010, WIDTH, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a_bit    = 1'($urandom_range(0, 1));
      b_bit    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("bp_o_valid", o_valid, 1'b1);
      check("bp_o", o, CMP_LT);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    o_ready  = 1'b1;
    take_result();
    send_word(4'b1110, 4'b1101, WIDTH, 0);
    take_result();

    // Asynchronous reset mid-word discards the partial word.
    send_word(4'b1000, 4'b0111, 2, 0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_o_valid", o_valid, 1'b0);
    check("arst_decided", decided, 1'b0);
    check("arst_o", o, CMP_EQ);
    check("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(4'b0010, 4'b0100, WIDTH, 0);
    take_result();

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
